// File: rtl/hdec_pipe.sv
// Two-stage pipelined N-to-2**N decoder (one-hot / half / inverted-half) with valid/ready flow control.
// Optional out_parity output (XOR of y) is enabled by defining HDEC_PIPE_PARITY_EN.
module hdec_pipe #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      x,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   y,
    output logic              out_err,
`ifdef HDEC_PIPE_PARITY_EN
    output logic              out_parity,
`endif
    output logic              busy
);

    localparam int W = 2**N;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_ONE_HOT  = 2'b00,
        MODE_HALF     = 2'b01,
        MODE_HALF_INV = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_t;

    logic          s1_valid;
    logic [N-1:0]  s1_x;
    mode_t         s1_mode;
    logic          s2_valid;
    logic          adv2;

    logic [W-1:0]  one_hot;
    logic [W-1:0]  below;
    logic [W-1:0]  y_next;
    logic          err_next;

    assign adv2      = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || adv2;
    assign out_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

    // One-hot minus one sets exactly the bits below x, so x=0 yields zero.
    always_comb begin
        one_hot  = ONE << s1_x;
        below    = one_hot - ONE;
        y_next   = '0;
        err_next = 1'b0;
        case (s1_mode)
            MODE_ONE_HOT:  y_next = one_hot;
            MODE_HALF:     y_next = below;
            MODE_HALF_INV: y_next = ~below;
            default: begin
                y_next   = '0;
                err_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_mode  <= MODE_ONE_HOT;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x    <= x;
                s1_mode <= mode_t'(mode);
            end
        end
    end

    // y and out_err only load with a real entry, so they hold after out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y        <= '0;
            out_err  <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y       <= y_next;
                out_err <= err_next;
            end
        end
    end

`ifdef HDEC_PIPE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (adv2 && s1_valid) begin
            out_parity <= ^y_next;
        end
    end
`endif

endmodule

// File: doc/hdec_pipe.md
HDEC_PIPE -- requirements
Module: hdec_pipe

Interface
REQ-001 The block SHALL have parameter N, default 4, input code width; output width is 2**N; legal range 1..8.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port in_valid  input  1  x/mode are valid this cycle.
REQ-005 The block SHALL have port in_ready  output  1  block accepts x/mode this cycle.
REQ-006 The block SHALL have port x  input  N  code to decode.
REQ-007 The block SHALL have port mode  input  2  decode mode, defined under Function.
REQ-008 The block SHALL have port out_valid  output  1  y/out_err hold a result.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 The block SHALL have port y  output  2**N  decoded vector.
REQ-011 The block SHALL have port out_err  output  1  result came from a reserved mode.
REQ-012 The block SHALL have port busy  output  1  high while either pipeline stage holds data.

Function
REQ-013 Transfers SHALL occur only on cycles with valid and ready both high, at both the input and output handshakes.
REQ-014 Stage 1 SHALL register x and mode on input transfer; stage 2 SHALL compute y from stage 1 and register it.
REQ-015 Latency SHALL be 2 cycles: a transfer at edge t yields out_valid at edge t+2 when not stalled.
REQ-016 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-017 adv2 = !s2_valid | out_ready; in_ready = !s1_valid | adv2; the ready path SHALL be combinational.
REQ-018 mode 00 (one-hot) SHALL drive y[i]=1 only for i==x.
REQ-019 mode 01 (half-decode) SHALL drive y[i]=1 for all i<x; x=0 gives all-zero y.
REQ-020 mode 10 (inverted half-decode) SHALL drive y[i]=1 for all i>=x; x=0 gives all-ones y.
REQ-021 mode 11 is reserved and SHALL produce y=0 with out_err=1; all other modes SHALL produce out_err=0.
REQ-022 While out_valid=1 and out_ready=0, y, out_err and out_valid SHALL hold stable, with no loss or reordering.
REQ-023 Under stall, stage 1 SHALL hold its entry and in_ready SHALL drop once both stages are full.
REQ-024 A stage SHALL accept a new entry and release its current one in the same cycle (no bubble).
REQ-025 After out_valid drops, y SHALL hold its last value; consumers SHALL ignore y when out_valid=0.
REQ-026 busy SHALL equal s1_valid | s2_valid.

Reset
REQ-027 On rst_n low, s1_valid, s2_valid, out_valid, busy, out_err and y SHALL clear to 0 immediately.
REQ-028 in_ready SHALL read 1 during and after reset.
REQ-029 Reset mid-operation SHALL discard all in-flight entries with no partial output.
REQ-030 Release of rst_n SHALL be synchronous to clk; the first transfer is legal on the first edge after release.

Configuration
REQ-031 With HDEC_PIPE_PARITY_EN defined, the block SHALL add port out_parity  output  1  = XOR of y, registered in stage 2, aligned with y, reset 0.
REQ-032 Without HDEC_PIPE_PARITY_EN, port out_parity and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 N=4, mode=01, x=4'b1000 -> y=16'h00FF, out_err=0, out_valid two cycles after the transfer.
REQ-034 N=4, mode=00, x=4'b0001, then mode=10, x=4'b0011 back-to-back -> y=16'h0002, then y=16'hFFF8 on consecutive cycles.
REQ-035 N=4, mode=11, x=4'b1100 -> y=16'h0000, out_err=1; with HDEC_PIPE_PARITY_EN, mode=01, x=4'b0011 gives y=16'h0007 and out_parity=1.
REQ-036 out_ready=0 for 4 cycles while in_valid=1 streams x=1,2,3 in mode 01 -> in_ready low after 2 accepts, y holds 16'h0001; after release, 16'h0003 then 16'h0007 follow, with none lost.
REQ-037 rst_n pulsed low with both stages full -> out_valid=0 and busy=0 at once, in_ready=1; no stale result appears after release.
